pc_fetch_unit: RTL and testbench

//   Program-counter owner and instruction-fetch front end of the single-cycle RISC-V core.

---
 rtl/pc_fetch_unit_pkg.sv | 19 +
 rtl/pc_fetch_unit_next_pc_mux.sv | 26 ++
 rtl/pc_fetch_unit.sv | 109 ++++++++++
 tb/tb_pc_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch front end: next-PC select encodings (also used by the
// control unit's PCSrc generator), fetch FSM states and the default reset PC.
package pc_fetch_unit_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
   localparam logic [1:0] PCSRC_TARGET = 2'b01;
   localparam logic [1:0] PCSRC_JALR   = 2'b10;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Combinational next-PC selection for the fetch unit, plus detection of a target that is
// not 4-byte aligned.
module next_pc_mux
   import pc_fetch_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] PC,
   input  logic [1:0]      PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   input  logic [XLEN-1:0] ALUResult,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned
);

   // The reserved select value falls through to sequential execution.
   always_comb begin
      case (PCSrc)
         PCSRC_TARGET: next_pc = PCTarget;
         PCSRC_JALR:   next_pc = ALUResult & ~XLEN'(1);
         default:      next_pc = PC + XLEN'(4);
      endcase
      misaligned = |next_pc[1:0];
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction-fetch front end: one outstanding fetch at a time,
// holds the fetched instruction until the datapath retires it, then moves to the next PC.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   input  logic [XLEN-1:0] ALUResult,
   input  logic            instr_ack,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic            misalign_err
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] next_pc;
   logic            misaligned;
   logic            capture;
   logic            retire;

   next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
      .PC        (PC),
      .PCSrc     (PCSrc),
      .PCTarget  (PCTarget),
      .ALUResult (ALUResult),
      .next_pc   (next_pc),
      .misaligned(misaligned)
   );

   // Data arrives either with the accepting handshake or later while waiting.
   assign capture = ((state == S_REQ) && imem_ready && imem_rvalid) ||
                    ((state == S_WAIT) && imem_rvalid);
   assign retire  = (state == S_HOLD) && instr_ack;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_REQ;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_REQ: begin
            if (imem_ready) begin
               state_next = imem_rvalid ? S_HOLD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ack) begin
               state_next = misaligned ? S_HALT : S_REQ;
            end
         end
         S_HALT: state_next = S_HALT;
      endcase
   end

   // No request may escape while reset is held, even though the state is already S_REQ.
   always_comb begin
      imem_req     = 1'b0;
      instr_valid  = 1'b0;
      misalign_err = 1'b0;
      case (state)
         S_REQ:   imem_req     = rst;
         S_HOLD:  instr_valid  = 1'b1;
         S_HALT:  misalign_err = 1'b1;
         default: ;
      endcase
   end

   // PC is still updated on a misaligned retire so the faulting target is visible.
   always_ff @(posedge clk) begin
      if (!rst) begin
         PC    <= RESET_PC;
         instr <= 32'h0;
      end else begin
         if (capture) begin
            instr <= imem_rdata;
         end
         if (retire) begin
            PC <= next_pc;
         end
      end
   end

   assign imem_addr = PC;
   assign PCPlus4   = PC + XLEN'(4);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a randomized memory responder and datapath, checked
// every cycle against a transaction-level model of PC sequencing and fetch handshakes.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  PCSrc;
   logic [31:0] PCTarget;
   logic [31:0] ALUResult;
   logic        instr_ack;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        misalign_err;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .PCSrc       (PCSrc),
      .PCTarget    (PCTarget),
      .ALUResult   (ALUResult),
      .instr_ack   (instr_ack),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .misalign_err(misalign_err)
   );

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: where the core should be and what it should be showing.
   logic [31:0] mPc;
   logic [31:0] mInstr;
   bit          mValid;
   bit          mReq;
   bit          mHalt;
   bit          mWaitData;
   int          reqCycles;
   int          readyDelay;
   int          dataDelay;
   int          waitLeft;

   // Knobs steering the stimulus.
   bit          zeroWait;
   bit          ackAlways;
   bit          plus4Only;
   bit          fixLatency;
   int          fixReady;
   int          fixData;
   int          misalignOdds;
   bit          forceEn;
   logic [1:0]  forceSel;
   logic [31:0] forceTgt;
   logic [31:0] forceAlu;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   // Architectural next-PC rule, wrapping naturally in 32-bit arithmetic.
   function automatic logic [31:0] refNextPc(input logic [31:0] pc, input logic [1:0] sel,
                                             input logic [31:0] tgt, input logic [31:0] alu);
      if (sel == 2'd1) return tgt;
      if (sel == 2'd2) return alu - (alu % 2);
      return pc + 32'd4;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic pickLatency();
      if (zeroWait) begin
         readyDelay = 0;
         dataDelay  = 0;
      end else if (fixLatency) begin
         readyDelay = fixReady;
         dataDelay  = fixData;
      end else begin
         readyDelay = $urandom_range(0, 3);
         dataDelay  = $urandom_range(0, 3);
      end
      reqCycles = 0;
   endtask

   task automatic doReset(input int cycles, input bit staleData);
      rst         = 1'b0;
      instr_ack   = 1'b0;
      PCSrc       = 2'd0;
      PCTarget    = 32'h0;
      ALUResult   = 32'h0;
      imem_ready  = staleData;
      imem_rvalid = staleData;
      imem_rdata  = 32'hDEAD_BEEF;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
         checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
         checkOutput("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
         checkOutput("rst_pc", PC, 32'h0);
         checkOutput("rst_instr", instr, 32'h0);
      end
      rst       = 1'b1;
      mPc       = 32'h0;
      mInstr    = 32'h0;
      mValid    = 1'b0;
      mReq      = 1'b1;
      mHalt     = 1'b0;
      mWaitData = 1'b0;
      pickLatency();
      #1;
   endtask

   // One cycle: compare the outputs with the model, then drive the next cycle's inputs
   // and advance the model to what those inputs should cause.
   task automatic applyStimulus();
      bit          doAck;
      logic [1:0]  sel;
      logic [31:0] tgt;
      logic [31:0] alu;
      logic [31:0] npc;

      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, mReq});
      checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, mValid});
      checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, mHalt});
      checkOutput("pc", PC, mPc);
      checkOutput("pc_plus4", PCPlus4, mPc + 32'd4);
      if (mReq) checkOutput("imem_addr", imem_addr, mPc);
      if (mValid) checkOutput("instr", instr, mInstr);

      imem_ready  = $urandom_range(0, 1);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      PCSrc       = $urandom_range(0, 3);
      PCTarget    = $urandom;
      ALUResult   = $urandom;
      instr_ack   = $urandom_range(0, 1);

      if (mReq) begin
         if (reqCycles == readyDelay) begin
            imem_ready = 1'b1;
            mReq       = 1'b0;
            if (dataDelay == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = memWord(mPc);
               mInstr      = memWord(mPc);
               mValid      = 1'b1;
            end else begin
               mWaitData = 1'b1;
               waitLeft  = dataDelay;
            end
         end else begin
            imem_ready  = 1'b0;
            imem_rvalid = ($urandom_range(0, 3) == 0);
            imem_rdata  = ~memWord(mPc);
            reqCycles++;
         end
      end else if (mWaitData) begin
         waitLeft--;
         if (waitLeft == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(mPc);
            mInstr      = memWord(mPc);
            mValid      = 1'b1;
            mWaitData   = 1'b0;
         end
      end else if (mValid) begin
         imem_rvalid = $urandom_range(0, 1);
         imem_rdata  = ~mInstr;
         doAck = ackAlways || forceEn || ($urandom_range(0, 2) == 0);
         instr_ack = doAck;
         if (doAck) begin
            if (forceEn) begin
               sel     = forceSel;
               tgt     = forceTgt;
               alu     = forceAlu;
               forceEn = 1'b0;
            end else begin
               sel = plus4Only ? 2'd0 : 2'($urandom_range(0, 3));
               tgt = $urandom & 32'hFFFF_FFFC;
               alu = $urandom & 32'hFFFF_FFFD;
               if (misalignOdds != 0 && $urandom_range(1, misalignOdds) == 1) begin
                  tgt = tgt | 32'($urandom_range(1, 3));
                  alu = alu | 32'h2;
               end
            end
            PCSrc     = sel;
            PCTarget  = tgt;
            ALUResult = alu;
            npc       = refNextPc(mPc, sel, tgt, alu);
            mPc       = npc;
            mValid    = 1'b0;
            if (npc % 4 != 0) begin
               mHalt = 1'b1;
            end else begin
               mReq = 1'b1;
               pickLatency();
            end
         end
      end else begin
         imem_rvalid = $urandom_range(0, 1);
      end

      @(negedge clk);
   endtask

   // Retire the next presented instruction with a chosen select, then let the following
   // fetch complete.
   task automatic forceAck(input logic [1:0] sel, input logic [31:0] tgt,
                           input logic [31:0] alu);
      forceSel = sel;
      forceTgt = tgt;
      forceAlu = alu;
      forceEn  = 1'b1;
      for (int i = 0; i < 40 && forceEn; i++) applyStimulus();
      for (int i = 0; i < 40 && !mValid && !mHalt; i++) applyStimulus();
   endtask

   initial begin
      int haltCycles;

      zeroWait     = 1'b1;
      ackAlways    = 1'b1;
      plus4Only    = 1'b1;
      fixLatency   = 1'b0;
      fixReady     = 0;
      fixData      = 0;
      misalignOdds = 0;
      forceEn      = 1'b0;

      // Zero-wait memory, sequential flow: addresses 0,4,8,C and valid every other cycle.
      doReset(2, 1'b0);
      repeat (12) applyStimulus();

      // Slow memory: ready after two request cycles, data three cycles after that.
      zeroWait   = 1'b0;
      ackAlways  = 1'b0;
      fixLatency = 1'b1;
      fixReady   = 2;
      fixData    = 3;
      doReset(1, 1'b0);
      repeat (24) applyStimulus();

      // Walk to PC 0x10, then exercise every select value.
      zeroWait   = 1'b1;
      fixLatency = 1'b0;
      ackAlways  = 1'b1;
      doReset(1, 1'b0);
      for (int i = 0; i < 40 && !(mValid && mPc == 32'h10); i++) applyStimulus();
      forceAck(2'd1, 32'h0000_0040, 32'h0);
      forceAck(2'd2, 32'h0, 32'h0000_0081);
      forceAck(2'd3, 32'h1234_5670, 32'h0);

      // Wrap from the top of the address space back to zero.
      forceAck(2'd1, 32'hFFFF_FFFC, 32'h0);
      forceAck(2'd0, 32'h0, 32'h0);
      repeat (4) applyStimulus();

      // Misaligned branch target halts fetch until reset.
      forceAck(2'd1, 32'h0000_0042, 32'h0);
      repeat (10) applyStimulus();

      // Reset while waiting for data; stale data around the reset must not be captured.
      zeroWait   = 1'b0;
      ackAlways  = 1'b0;
      fixLatency = 1'b1;
      fixReady   = 0;
      fixData    = 4;
      doReset(1, 1'b0);
      for (int i = 0; i < 10 && !mWaitData; i++) applyStimulus();
      applyStimulus();
      fixReady = 1;
      fixData  = 2;
      doReset(2, 1'b1);
      repeat (20) applyStimulus();

      // Randomized traffic with occasional misalignment and recovery through reset.
      fixLatency   = 1'b0;
      plus4Only    = 1'b0;
      misalignOdds = 12;
      haltCycles   = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 500 == 0) zeroWait = ~zeroWait;
         applyStimulus();
         if (mHalt) begin
            haltCycles++;
            if (haltCycles >= 4) begin
               haltCycles = 0;
               doReset($urandom_range(1, 2), 1'($urandom_range(0, 1)));
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
